// File: rtl/cnn_stream_ctrl_if.sv
// Load/result stream bundle for cnn_stream_ctrl.
// Inbound beats flow s_* (TB -> ctrl); results flow m_* (ctrl -> TB).
interface cnn_stream_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_last;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/cnn_stream_ctrl.sv
// Stream controller feeding a CNN accelerator: loads kernel + ifmap from a beat
// stream, runs the accelerator until done, then drains the pooled result.
module cnn_stream_ctrl #(
    parameter int DATA_WIDTH      = 8,
    parameter int IFMAP_SIZE      = 8,
    parameter int KERNEL_SIZE     = 3,
    parameter int POOL_OFMAP_SIZE = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    cnn_stream_ctrl_if.slave             bus,
    output logic        [DATA_WIDTH-1:0] acc_ifmap   [IFMAP_SIZE][IFMAP_SIZE],
    output logic signed [DATA_WIDTH-1:0] acc_weights [KERNEL_SIZE][KERNEL_SIZE],
    input  logic        [DATA_WIDTH-1:0] acc_ofmap   [POOL_OFMAP_SIZE][POOL_OFMAP_SIZE],
    output logic                         acc_en,
    output logic                         acc_clear,
    input  logic                         acc_done,
    output logic                         busy,
    output logic                         err
);
    localparam int KW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int XW = (IFMAP_SIZE > 1) ? $clog2(IFMAP_SIZE) : 1;
    localparam int OW = (POOL_OFMAP_SIZE > 1) ? $clog2(POOL_OFMAP_SIZE) : 1;

    typedef enum logic [2:0] {CLEAR, LOAD_W, LOAD_X, RUN, DRAIN} state_t;

    state_t                r_state, w_next;
    logic [KW-1:0]         r_wr, r_wc;
    logic [XW-1:0]         r_xr, r_xc;
    logic [OW-1:0]         r_or, r_oc;
    logic [DATA_WIDTH-1:0] r_buf [POOL_OFMAP_SIZE][POOL_OFMAP_SIZE];

    logic w_beat, w_mxfer, w_w_last, w_x_last, w_o_last, w_early, w_missing;

    assign w_beat    = bus.s_valid && bus.s_ready;
    assign w_mxfer   = bus.m_valid && bus.m_ready;
    assign w_w_last  = (r_wr == KW'(KERNEL_SIZE - 1)) && (r_wc == KW'(KERNEL_SIZE - 1));
    assign w_x_last  = (r_xr == XW'(IFMAP_SIZE - 1)) && (r_xc == XW'(IFMAP_SIZE - 1));
    assign w_o_last  = (r_or == OW'(POOL_OFMAP_SIZE - 1)) && (r_oc == OW'(POOL_OFMAP_SIZE - 1));
    // s_last is legal only on the very last ifmap beat of a frame
    assign w_early   = w_beat && bus.s_last && !((r_state == LOAD_X) && w_x_last);
    assign w_missing = w_beat && !bus.s_last && (r_state == LOAD_X) && w_x_last;

    always_ff @(posedge clk) begin
        if (!reset) r_state <= CLEAR;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        bus.s_ready = 1'b0;
        bus.m_valid = 1'b0;
        bus.m_data  = '0;
        bus.m_last  = 1'b0;
        acc_en      = 1'b0;
        acc_clear   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            CLEAR: begin
                acc_clear = 1'b1;
                w_next    = LOAD_W;
            end
            LOAD_W: begin
                bus.s_ready = 1'b1;
                busy        = !((r_wr == '0) && (r_wc == '0));
                if (w_beat) begin
                    if (bus.s_last)    w_next = CLEAR;
                    else if (w_w_last) w_next = LOAD_X;
                end
            end
            LOAD_X: begin
                bus.s_ready = 1'b1;
                if (w_beat) begin
                    if (w_early)       w_next = CLEAR;
                    else if (w_x_last) w_next = RUN;
                end
            end
            RUN: begin
                acc_en = 1'b1;
                if (acc_done) w_next = DRAIN;
            end
            DRAIN: begin
                bus.m_valid = 1'b1;
                bus.m_data  = r_buf[r_or][r_oc];
                bus.m_last  = w_o_last;
                if (w_mxfer && w_o_last) w_next = CLEAR;
            end
            default: w_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr <= '0;
            r_wc <= '0;
            r_xr <= '0;
            r_xc <= '0;
            r_or <= '0;
            r_oc <= '0;
            err  <= 1'b0;
            for (int r = 0; r < KERNEL_SIZE; r++)
                for (int c = 0; c < KERNEL_SIZE; c++) acc_weights[r][c] <= '0;
            for (int r = 0; r < IFMAP_SIZE; r++)
                for (int c = 0; c < IFMAP_SIZE; c++) acc_ifmap[r][c] <= '0;
            for (int r = 0; r < POOL_OFMAP_SIZE; r++)
                for (int c = 0; c < POOL_OFMAP_SIZE; c++) r_buf[r][c] <= '0;
        end else begin
            if (w_early || w_missing) err <= 1'b1;
            case (r_state)
                CLEAR: begin
                    r_wr <= '0;
                    r_wc <= '0;
                    r_xr <= '0;
                    r_xc <= '0;
                    r_or <= '0;
                    r_oc <= '0;
                end
                LOAD_W: if (w_beat && !bus.s_last) begin
                    acc_weights[r_wr][r_wc] <= bus.s_data;
                    if (r_wc == KW'(KERNEL_SIZE - 1)) begin
                        r_wc <= '0;
                        r_wr <= (r_wr == KW'(KERNEL_SIZE - 1)) ? '0 : r_wr + 1'b1;
                    end else begin
                        r_wc <= r_wc + 1'b1;
                    end
                end
                LOAD_X: if (w_beat && !w_early) begin
                    acc_ifmap[r_xr][r_xc] <= bus.s_data;
                    if (r_xc == XW'(IFMAP_SIZE - 1)) begin
                        r_xc <= '0;
                        r_xr <= (r_xr == XW'(IFMAP_SIZE - 1)) ? '0 : r_xr + 1'b1;
                    end else begin
                        r_xc <= r_xc + 1'b1;
                    end
                end
                RUN: if (acc_done) r_buf <= acc_ofmap;
                DRAIN: if (w_mxfer) begin
                    if (r_oc == OW'(POOL_OFMAP_SIZE - 1)) begin
                        r_oc <= '0;
                        r_or <= (r_or == OW'(POOL_OFMAP_SIZE - 1)) ? '0 : r_or + 1'b1;
                    end else begin
                        r_oc <= r_oc + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
